fetch_queue_pc: RTL and testbench
=================================

Name: fetch_queue_pc

Overview:
- Parametrised successor to the single-register PC plus fixed +4 adder: sequential instruction-fetch front end.
- Owns the fetch PC and issues reads to the 1-cycle-latency instruction memory.
- Buffers returned instructions with their PCs in a small queue and hands them to decode over a valid/ready handshake.
- Supports a branch redirect that flushes all queued and in-flight fetches.

Parameters:
XLEN, 64, address/PC and instruction-word width
INC, 4, PC increment per fetch (power of two)
RESET_PC, 0, PC value loaded on reset
DEPTH, 4, queue entries (power of two, >=2); also the cap on queued + in-flight fetches

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
mem_rd_en  out  1  read request to instruction memory this cycle
mem_addr  out  XLEN  read address; valid when mem_rd_en=1
mem_rdata  in  XLEN  read data for the request issued the previous cycle
out_valid  out  1  queue head valid
out_ready  in  1  decode accepts head
out_pc  out  XLEN  PC of head entry
out_instr  out  XLEN  instruction word of head entry
redirect_valid  in  1  branch/jump taken: flush and restart
redirect_pc  in  XLEN  new fetch PC
occupancy  out  log2(DEPTH)+1  entries currently in queue

Behaviour:
- Clock and reset: one clock (clk); reset is asynchronous and active-high.
- Reset values: fetch_pc=RESET_PC, mem_rd_en=0, queue empty, out_valid=0, occupancy=0, in-flight flag=0. Reset asserted mid-operation discards all state immediately; no response is pushed after reset.
- Issue:
  - mem_rd_en is combinational: asserted when not in reset and redirect_valid=0 and (occupancy + inflight) < DEPTH.
  - mem_addr = fetch_pc.
  - When mem_rd_en=1, fetch_pc <= fetch_pc + INC (modulo 2^XLEN, so wrap to 0 is legal), inflight <= 1, and the request PC is latched as resp_pc.
- Response: a cycle with inflight=1 pushes {resp_pc, mem_rdata} into the queue. inflight clears unless a new request issued the same cycle.
- Latency: first request on the first clk edge after reset release. Data is pushed one cycle later; out_valid rises the cycle after the push. Fetch-to-output latency is 2 cycles.
- Throughput: 1 fetch/cycle sustained when out_ready=1.
- Credit rule: push with a full queue is impossible by construction. Simultaneous push and pop is allowed at any occupancy, including full; occupancy is unchanged in that case.
- Output: out_pc/out_instr are registered head fields. Pop occurs when out_valid && out_ready. Fields hold stable while out_valid=1 and out_ready=0.
- Redirect (cycle with redirect_valid=1):
  - A head handshake in the same cycle still completes (entry counts as delivered).
  - Queue is then flushed to empty and any in-flight response is dropped.
  - fetch_pc <= redirect_pc with its low log2(INC) bits forced to 0. No request issues that cycle; the next cycle issues at the new PC.
  - Back-to-back redirects: the last one wins.
- Empty queue: out_valid=0; out_pc/out_instr hold their last values (don't-care to consumers).
- No combinational path from out_ready to mem_rd_en other than through the registered occupancy.

Decomposition:
- Shared package fetch_pkg:
  - XLEN default constant.
  - fetch_entry_t struct {pc, instr}.
  - Function clog2-based occupancy width helper.
- Sub-module sync_fifo (parametrised WIDTH, DEPTH):
  - Inputs: push, pop, flush.
  - Outputs: head, count.
  - Asynchronous active-high reset.
  - Instantiated once with WIDTH=2*XLEN.
- Top module holds the PC register, credit logic, inflight/epoch tracking and redirect control.

Test Plan:
- Reset release, out_ready=1, memory returns data=addr/4 -> mem_addr 0,4,8,12… on consecutive cycles. First out_valid 2 cycles after the first request, with out_pc=0, out_instr=0; then one entry per cycle in order.
- out_ready=0 held for 10 cycles (DEPTH=4) -> exactly 4 requests issued (addr 0..12), occupancy=4, mem_rd_en=0 thereafter. Release out_ready -> entries 0,4,8,12 delivered, then fetch resumes at 16.
- Redirect to 0x103 while queue holds 3 entries and one fetch is in flight -> queue empties next cycle and the in-flight data is never output. Next request addr=0x100, and the first out_pc after the redirect is 0x100.
- Redirect in the same cycle as an out_valid && out_ready handshake -> that head is consumed exactly once; no later output carries the pre-redirect PCs.
- RESET_PC=0xFFFFFFFFFFFFFFF8 -> fetch addresses 0x…F8, 0x…FC, 0x0, 0x4 (wrap); out_pc values match.
- Assert reset asynchronously mid-burst (between edges) -> mem_rd_en=0, out_valid=0, occupancy=0 immediately. After release, fetch restarts at RESET_PC with no stale entry output.

Source files
------------

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared definitions for the instruction-fetch front end.
//   FETCH_XLEN    default address / instruction-word width
//   fetch_entry_t {pc, instr} pair as delivered to decode
//   occ_width()   width of an occupancy counter able to hold 0..depth
package fetch_pkg;

    localparam int unsigned FETCH_XLEN = 64;

    typedef struct packed {
        logic [FETCH_XLEN-1:0] pc;
        logic [FETCH_XLEN-1:0] instr;
    } fetch_entry_t;

    function automatic int unsigned occ_width(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with flush, power-of-two DEPTH.
//   clk_i    clock, rising edge
//   rst_i    asynchronous active-high reset
//   push_i   write din_i (accepted when not full, or when popping this cycle)
//   pop_i    drop the head entry (ignored when empty)
//   flush_i  empty the FIFO; overrides push_i, a same-cycle pop still counts
//   din_i    write data
//   head_o   head entry; when empty, the most recently delivered entry
//   count_o  number of stored entries, 0..DEPTH
module sync_fifo
    import fetch_pkg::*;
#(
    parameter int unsigned WIDTH = 2 * FETCH_XLEN,
    parameter int unsigned DEPTH = 4
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        push_i,
    input  logic                        pop_i,
    input  logic                        flush_i,
    input  logic [WIDTH-1:0]            din_i,
    output logic [WIDTH-1:0]            head_o,
    output logic [occ_width(DEPTH)-1:0] count_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = occ_width(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    rd_ptr_q;
    logic [AW-1:0]    wr_ptr_q;
    logic [CW-1:0]    count_q;
    logic             do_push;
    logic             do_pop;

    assign do_pop  = pop_i && (count_q != '0);
    assign do_push = push_i && ((count_q != CW'(DEPTH)) || do_pop);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            // Collapse both pointers onto the post-pop read position so the
            // slot just behind rd_ptr still holds the last delivered entry.
            rd_ptr_q <= rd_ptr_q + AW'(do_pop);
            wr_ptr_q <= rd_ptr_q + AW'(do_pop);
            count_q  <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= din_i;
                wr_ptr_q        <= wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            count_q <= count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    // Empty: keep presenting the last delivered entry instead of a stale slot.
    assign head_o  = (count_q == '0) ? mem_q[rd_ptr_q - AW'(1)] : mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/fetch_queue_pc.sv
// fetch_queue_pc: sequential instruction-fetch front end.
// Owns the fetch PC, issues reads to a 1-cycle-latency instruction memory,
// queues {pc, instr} responses and hands them to decode over valid/ready.
// A redirect flushes all queued and in-flight fetches and restarts fetch.
//   clk            clock, rising edge
//   reset          asynchronous active-high reset
//   mem_rd_en      read request this cycle
//   mem_addr       read address (the fetch PC)
//   mem_rdata      read data for the request issued the previous cycle
//   out_valid      queue head valid
//   out_ready      decode accepts head
//   out_pc         PC of head entry
//   out_instr      instruction word of head entry
//   redirect_valid taken branch/jump: flush and restart
//   redirect_pc    new fetch PC (low log2(INC) bits ignored)
//   occupancy      entries currently queued
module fetch_queue_pc
    import fetch_pkg::*;
#(
    parameter int unsigned     XLEN     = FETCH_XLEN,
    parameter int unsigned     INC      = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int unsigned     DEPTH    = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    output logic                        mem_rd_en,
    output logic [XLEN-1:0]             mem_addr,
    input  logic [XLEN-1:0]             mem_rdata,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [XLEN-1:0]             out_pc,
    output logic [XLEN-1:0]             out_instr,
    input  logic                        redirect_valid,
    input  logic [XLEN-1:0]             redirect_pc,
    output logic [occ_width(DEPTH)-1:0] occupancy
);

    localparam int unsigned     OW         = occ_width(DEPTH);
    localparam logic [XLEN-1:0] INC_V      = XLEN'(INC);
    localparam logic [XLEN-1:0] ALIGN_MASK = ~(INC_V - XLEN'(1));

    logic [XLEN-1:0]   fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0]   resp_pc_q, resp_pc_d;
    logic              inflight_q, inflight_d;
    logic [OW-1:0]     credit_used;
    logic              push;
    logic              pop;
    logic [2*XLEN-1:0] head;

    // Queued plus in-flight entries may never exceed DEPTH, so a response
    // always finds a free slot and out_ready reaches issue only through
    // the registered occupancy.
    assign credit_used = occupancy + OW'(inflight_q);
    assign mem_rd_en   = !reset && !redirect_valid && (credit_used < OW'(DEPTH));
    assign mem_addr    = fetch_pc_q;

    // A response landing in a redirect cycle belongs to the old stream.
    assign push      = inflight_q && !redirect_valid;
    assign pop       = out_valid && out_ready;
    assign out_valid = (occupancy != '0);

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        resp_pc_d  = resp_pc_q;
        inflight_d = mem_rd_en;
        if (redirect_valid) begin
            fetch_pc_d = redirect_pc & ALIGN_MASK;
        end else if (mem_rd_en) begin
            fetch_pc_d = fetch_pc_q + INC_V;
            resp_pc_d  = fetch_pc_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_pc_q <= RESET_PC;
            resp_pc_q  <= '0;
            inflight_q <= 1'b0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            resp_pc_q  <= resp_pc_d;
            inflight_q <= inflight_d;
        end
    end

    sync_fifo #(
        .WIDTH (2 * XLEN),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i   (clk),
        .rst_i   (reset),
        .push_i  (push),
        .pop_i   (pop),
        .flush_i (redirect_valid),
        .din_i   ({resp_pc_q, mem_rdata}),
        .head_o  (head),
        .count_o (occupancy)
    );

    assign out_pc    = head[2*XLEN-1:XLEN];
    assign out_instr = head[XLEN-1:0];

endmodule

// File: tb/tb_fetch_queue_pc.sv
// tb_fetch_queue_pc: self-checking bench for fetch_queue_pc.
// dut0 (defaults) is checked every cycle against a queue-based reference
// model; dut1 (RESET_PC near the top of the address space) checks wrap.
module tb_fetch_queue_pc;
    import fetch_pkg::*;

    localparam int unsigned DEPTH    = 4;
    localparam logic [63:0] WRAP_PC  = 64'hFFFF_FFFF_FFFF_FFF8;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        mem_rd_en;
    logic [63:0] mem_addr;
    logic [63:0] mem_rdata = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [63:0] out_pc;
    logic [63:0] out_instr;
    logic        redirect_valid = 1'b0;
    logic [63:0] redirect_pc = '0;
    logic [2:0]  occupancy;

    logic        reset1 = 1'b1;
    logic        mem_rd_en1;
    logic [63:0] mem_addr1;
    logic [63:0] mem_rdata1 = '0;
    logic        out_valid1;
    logic [63:0] out_pc1;
    logic [63:0] out_instr1;
    logic [2:0]  occupancy1;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state.
    fetch_entry_t mq[$];
    logic [63:0]  m_pc;
    logic         m_inf;
    logic [63:0]  m_ipc;

    always #5 clk = ~clk;

    // Instruction memory: word at address a holds a/4, one cycle latency.
    always @(posedge clk) begin
        mem_rdata  <= mem_addr >> 2;
        mem_rdata1 <= mem_addr1 >> 2;
    end

    fetch_queue_pc #(.XLEN(64), .INC(4), .RESET_PC(64'h0), .DEPTH(DEPTH)) dut0 (
        .clk(clk), .reset(reset), .mem_rd_en(mem_rd_en), .mem_addr(mem_addr),
        .mem_rdata(mem_rdata), .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_instr(out_instr), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .occupancy(occupancy)
    );

    fetch_queue_pc #(.XLEN(64), .INC(4), .RESET_PC(WRAP_PC), .DEPTH(DEPTH)) dut1 (
        .clk(clk), .reset(reset1), .mem_rd_en(mem_rd_en1), .mem_addr(mem_addr1),
        .mem_rdata(mem_rdata1), .out_valid(out_valid1), .out_ready(1'b1),
        .out_pc(out_pc1), .out_instr(out_instr1), .redirect_valid(1'b0),
        .redirect_pc(64'h0), .occupancy(occupancy1)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_pc  = 64'h0;
        m_inf = 1'b0;
        m_ipc = 64'h0;
    endtask

    // One clock cycle of dut0: compare outputs with the model, advance the
    // model by the rules of the fetch front end, then cross the next edge.
    task automatic step();
        logic         exp_en;
        fetch_entry_t e;
        #1;
        exp_en = !reset && !redirect_valid && ((mq.size() + (m_inf ? 1 : 0)) < DEPTH);
        check("mem_rd_en", {63'h0, mem_rd_en}, {63'h0, exp_en});
        if (exp_en) check("mem_addr", mem_addr, m_pc);
        check("occupancy", {61'h0, occupancy}, 64'(mq.size()));
        check("out_valid", {63'h0, out_valid}, {63'h0, mq.size() != 0});
        if (mq.size() != 0) begin
            check("out_pc", out_pc, mq[0].pc);
            check("out_instr", out_instr, mq[0].instr);
        end
        if (!reset) begin
            if (mq.size() != 0 && out_ready) void'(mq.pop_front());
            if (redirect_valid) begin
                mq.delete();
                m_inf = 1'b0;
                m_pc  = redirect_pc & ~64'h3;
            end else begin
                if (m_inf) begin
                    e.pc    = m_ipc;
                    e.instr = m_ipc >> 2;
                    mq.push_back(e);
                end
                m_inf = exp_en;
                if (exp_en) begin
                    m_ipc = m_pc;
                    m_pc  = m_pc + 64'd4;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        model_reset();
        @(posedge clk);
        #1;
        // Reset state.
        step();
        step();

        // Wrap-around instance: addresses F8, FC, 0, 4, ... with matching out_pc.
        reset1 = 1'b0;
        for (int k = 0; k < 6; k++) begin
            #1;
            check("wrap_rd_en", {63'h0, mem_rd_en1}, 64'h1);
            check("wrap_addr", mem_addr1, WRAP_PC + 64'(4 * k));
            check("wrap_valid", {63'h0, out_valid1}, {63'h0, k >= 2});
            if (k >= 2) begin
                check("wrap_out_pc", out_pc1, WRAP_PC + 64'(4 * (k - 2)));
                check("wrap_out_instr", out_instr1, (WRAP_PC + 64'(4 * (k - 2))) >> 2);
            end
            @(posedge clk);
            #1;
        end

        // Streaming from reset release.
        reset = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) step();

        // Back-pressure: queue fills to DEPTH and issue stops.
        out_ready = 1'b0;
        for (int i = 0; i < 10; i++) step();
        check("full_occupancy", {61'h0, occupancy}, 64'd4);
        check("full_rd_en", {63'h0, mem_rd_en}, 64'h0);

        // Drain and resume.
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) step();

        // Redirect with three queued entries and one fetch in flight.
        out_ready = 1'b0;
        for (int i = 0; i < 20 && !(mq.size() == 3 && m_inf); i++) step();
        check("pre_redirect_occ", {61'h0, occupancy}, 64'd3);
        redirect_valid = 1'b1;
        redirect_pc    = 64'h103;
        step();
        check("post_redirect_occ", {61'h0, occupancy}, 64'd0);
        redirect_valid = 1'b0;
        #1;
        check("post_redirect_addr", mem_addr, 64'h100);
        check("post_redirect_rd_en", {63'h0, mem_rd_en}, 64'h1);
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) step();

        // Redirect coinciding with a head handshake.
        redirect_valid = 1'b1;
        redirect_pc    = 64'h400;
        step();
        redirect_valid = 1'b0;
        for (int i = 0; i < 6; i++) step();

        // Back-to-back redirects: the last one wins.
        redirect_valid = 1'b1;
        redirect_pc    = 64'h200;
        step();
        redirect_pc    = 64'h305;
        step();
        redirect_valid = 1'b0;
        for (int i = 0; i < 6; i++) step();

        // Random traffic.
        for (int i = 0; i < 300; i++) begin
            out_ready      = ($urandom_range(0, 99) < 70);
            redirect_valid = ($urandom_range(0, 99) < 5);
            redirect_pc    = {$urandom, $urandom};
            step();
        end
        redirect_valid = 1'b0;

        // Asynchronous reset between edges with a partly full queue.
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) step();
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("async_rst_rd_en", {63'h0, mem_rd_en}, 64'h0);
        check("async_rst_valid", {63'h0, out_valid}, 64'h0);
        check("async_rst_occ", {61'h0, occupancy}, 64'd0);
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
